fust_s_multi: RTL and testbench
===============================

// Module: fust_s_multi
// PURPOSE
//  Parametrised scalar functional-unit status table: NUM_FU units, DEPTH slots each.
//  Sits between dispatch and issue. Per slot it holds:
//   - an op payload;
//   - two source tags, cleared by writeback tag broadcast;
//   - a speculation bit.
//  Each cycle it offers the oldest ready slot per FU to that FU. Supersedes single-slot fust_s_t tracking.
// PARAMETERS
//  NUM_FU   3   number of scalar FUs (ALU, LD/ST, BRANCH by default)
//  DEPTH    2   slots per FU; power of two >= 1
//  OP_W     80  width of opaque op payload (packed fust_s_row_t)
//  TAG_W    $clog2(NUM_FU*DEPTH+1)  tag width; tag 0 = "no dependency"
// PORTS
//  CLK          in   1             clock, rising edge
//  nRST         in   1             asynchronous active-low reset
//  disp_en      in   1             dispatch request this cycle
//  disp_fu      in   $clog2(NUM_FU) target FU index
//  disp_op      in   OP_W          op payload
//  disp_t1      in   TAG_W         producer tag of rs1 (0 = ready)
//  disp_t2      in   TAG_W         producer tag of rs2 (0 = ready)
//  disp_spec    in   1             op issued under unresolved branch
//  disp_tag     out  TAG_W         tag assigned to this dispatch (comb.; 0 if not accepted)
//  fu_full      out  NUM_FU        per-FU all slots non-EMPTY
//  disp_drop    out  1             registered pulse: disp_en rejected (full/flush)
//  done         in   NUM_FU        FU k completed op with done_tag[k]
//  done_tag     in   NUM_FU*TAG_W  completing tags, FU k at [k*TAG_W +: TAG_W]
//  iss_valid    out  NUM_FU        FU k has a ready op offered
//  iss_ready    in   NUM_FU        FU k accepts offered op
//  iss_op       out  NUM_FU*OP_W   offered payloads
//  iss_tag      out  NUM_FU*TAG_W  offered slot tags
//  br_resolved  in   1             oldest branch predicted correctly: clear all spec bits
//  br_miss      in   1             mispredict: flush all spec slots
// BEHAVIOUR
//  - Slot state uses fust_state_e: FUST_EMPTY/FUST_WAIT/FUST_RDY/FUST_EX.
//  - Tag of slot s in FU f = f*DEPTH+s+1.
//  - Reset (nRST=0, async): all slots EMPTY, tags/spec/age cleared.
//    All outputs 0, except fu_full = 0.
//  - Dispatch: accepted if disp_en & !fu_full[disp_fu] & !(br_miss & disp_spec).
//    - Slot chosen: lowest-index EMPTY slot of disp_fu; disp_tag is driven that same cycle.
//    - Next cycle the slot is WAIT if any stored tag != 0, else RDY.
//    - Rejected dispatch: disp_drop=1 next cycle, table unchanged.
//  - Wakeup: for each done[k], tags equal to done_tag[k] are cleared in every slot.
//    - WAIT->RDY when both tags are 0 after clearing; takes effect next cycle.
//    - Same-cycle bypass: disp_t1/t2 equal to any active done_tag are stored as 0.
//  - Completion: slot whose tag == done_tag[k] with done[k] goes EX->EMPTY.
//    - done for a non-EX slot is ignored (slot already flushed).
//  - Issue: iss_valid[f] = any RDY slot in FU f.
//    - Offered slot is the oldest RDY slot by dispatch order (per-FU age matrix).
//    - iss_op/iss_tag are combinational from table.
//    - Handshake: iss_valid&iss_ready -> slot RDY->EX next cycle.
//    - Offer stays stable while unaccepted, unless an older slot becomes RDY or a flush occurs.
//  - Speculation:
//    - br_resolved clears spec in all slots.
//    - br_miss sets every spec=1 slot (any state, incl. EX) to EMPTY next cycle.
//    - br_miss beats br_resolved when both are asserted.
//    - Issue handshake on a flushed slot in the br_miss cycle is voided (slot goes EMPTY).
//  - Simultaneous completion and dispatch to the same FU: the freed slot is not reusable until next cycle.
//    fu_full is computed from current state only.
//  - DEPTH=1 degenerates to single-slot table; age logic constant.
// STRUCTURE
//  - datapath_pkg gets:
//    - fust_slot_t {fust_state_e st; tag t1,t2; spec; op};
//    - localparam tag helpers (fu/slot <-> tag).
//  - Sub-module fust_age_sel: per-FU DEPTH x DEPTH age matrix; given a RDY mask, outputs the one-hot oldest slot.
//    Instantiated NUM_FU times.
// TESTING
//  1. Reset mid-run with 4 slots busy:
//     -> all iss_valid=0, fu_full=0, disp_tag=0 immediately on nRST low.
//  2. Dispatch ALU op t1=0,t2=0:
//     -> disp_tag=1 same cycle, iss_valid[0]=1 next cycle.
//     Accept with iss_ready -> EX; done_tag=1 -> slot EMPTY.
//  3. Dispatch FU1 op with t1=1 while done[0]=1,done_tag=1 same cycle:
//     -> stored t1=0, RDY next cycle (bypass).
//  4. Fill FU0 (DEPTH=2) then third dispatch to FU0:
//     -> fu_full[0]=1, disp_drop pulses, table unchanged.
//  5. Two RDY slots in FU0, slot1 dispatched first:
//     -> iss_tag[0]=2 offered before tag 1.
//  6. Slots spec=1 in WAIT and EX, one spec=0 RDY; pulse br_miss with br_resolved:
//     -> spec slots EMPTY, spec=0 slot still offered; late done for flushed tag ignored.

Source files
------------

// File: rtl/fust_s_multi_pkg.sv
// Shared types and tag helpers for the multi-slot scalar FU status table.
package fust_s_multi_pkg;

  localparam int unsigned NUM_FU_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned OP_W_DEF   = 80;
  localparam int unsigned TAG_W_DEF  = $clog2(NUM_FU_DEF * DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    FUST_EMPTY = 2'd0,
    FUST_WAIT  = 2'd1,
    FUST_RDY   = 2'd2,
    FUST_EX    = 2'd3
  } fust_state_e;

  typedef struct packed {
    fust_state_e            st;
    logic [TAG_W_DEF-1:0]   t1;
    logic [TAG_W_DEF-1:0]   t2;
    logic                   spec;
    logic [OP_W_DEF-1:0]    op;
  } fust_slot_t;

  // Tag 0 is reserved for "no dependency", so slot tags start at 1.
  function automatic int unsigned slot_tag(int unsigned fu, int unsigned slot, int unsigned depth);
    return fu * depth + slot + 1;
  endfunction

  function automatic int unsigned tag_fu(int unsigned tag, int unsigned depth);
    return (tag - 1) / depth;
  endfunction

  function automatic int unsigned tag_slot(int unsigned tag, int unsigned depth);
    return (tag - 1) % depth;
  endfunction

endpackage

// File: rtl/fust_age_sel.sv
// Per-FU dispatch-order tracker: picks the oldest slot out of a ready mask.
module fust_age_sel #(
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [DEPTH-1:0] alloc_oh_i,
  input  logic [DEPTH-1:0] rdy_i,
  output logic [DEPTH-1:0] oldest_o
);

  // older_q[i][j] set means slot i was dispatched before slot j
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc_oh_i[i]) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          older_d[i][j] = 1'b0;
          older_d[j][i] = (i != j);
        end
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      oldest_o[i] = rdy_i[i];
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (rdy_i[j] && older_q[j][i]) oldest_o[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) older_q <= '0;
    else       older_q <= older_d;
  end

endmodule

// File: rtl/fust_s_multi.sv
// Scalar FU status table: NUM_FU units x DEPTH slots with tag wakeup,
// oldest-ready issue selection and branch speculation flush.
module fust_s_multi
  import fust_s_multi_pkg::*;
#(
  parameter  int unsigned NUM_FU = NUM_FU_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  parameter  int unsigned OP_W   = OP_W_DEF,
  parameter  int unsigned TAG_W  = $clog2(NUM_FU * DEPTH + 1),
  localparam int unsigned FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    disp_en,
  input  logic [FU_W-1:0]         disp_fu,
  input  logic [OP_W-1:0]         disp_op,
  input  logic [TAG_W-1:0]        disp_t1,
  input  logic [TAG_W-1:0]        disp_t2,
  input  logic                    disp_spec,
  output logic [TAG_W-1:0]        disp_tag,
  output logic [NUM_FU-1:0]       fu_full,
  output logic                    disp_drop,
  input  logic [NUM_FU-1:0]       done,
  input  logic [NUM_FU*TAG_W-1:0] done_tag,
  output logic [NUM_FU-1:0]       iss_valid,
  input  logic [NUM_FU-1:0]       iss_ready,
  output logic [NUM_FU*OP_W-1:0]  iss_op,
  output logic [NUM_FU*TAG_W-1:0] iss_tag,
  input  logic                    br_resolved,
  input  logic                    br_miss
);

  fust_state_e      st_q   [NUM_FU][DEPTH];
  fust_state_e      st_d   [NUM_FU][DEPTH];
  logic [TAG_W-1:0] t1_q   [NUM_FU][DEPTH];
  logic [TAG_W-1:0] t1_d   [NUM_FU][DEPTH];
  logic [TAG_W-1:0] t2_q   [NUM_FU][DEPTH];
  logic [TAG_W-1:0] t2_d   [NUM_FU][DEPTH];
  logic             spec_q [NUM_FU][DEPTH];
  logic             spec_d [NUM_FU][DEPTH];
  logic [OP_W-1:0]  op_q   [NUM_FU][DEPTH];
  logic [OP_W-1:0]  op_d   [NUM_FU][DEPTH];
  logic             disp_drop_q, disp_drop_d;

  logic [NUM_FU-1:0][DEPTH-1:0] rdy_mask, free_oh, alloc_oh, offer_oh;
  logic                         sel_full, disp_acc;
  logic [TAG_W-1:0]             disp_t1_w, disp_t2_w;

  // A source tag matching any completing tag this cycle reads as ready.
  function automatic logic [TAG_W-1:0] wake(input logic [TAG_W-1:0] t,
                                            input logic [NUM_FU-1:0] dn,
                                            input logic [NUM_FU*TAG_W-1:0] dt);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (dn[k] && (dt[k*TAG_W +: TAG_W] == t)) hit = 1'b1;
    end
    return hit ? '0 : t;
  endfunction

  function automatic logic done_match(input logic [TAG_W-1:0] t,
                                      input logic [NUM_FU-1:0] dn,
                                      input logic [NUM_FU*TAG_W-1:0] dt);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (dn[k] && (dt[k*TAG_W +: TAG_W] == t)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Occupancy view of the current table only.
  always_comb begin
    rdy_mask = '0;
    free_oh  = '0;
    fu_full  = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      fu_full[f] = 1'b1;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        rdy_mask[f][s] = (st_q[f][s] == FUST_RDY);
        if (st_q[f][s] == FUST_EMPTY) fu_full[f] = 1'b0;
      end
      for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
        if (st_q[f][s] == FUST_EMPTY) begin
          free_oh[f]    = '0;
          free_oh[f][s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_full = 1'b1;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (disp_fu == FU_W'(f)) sel_full = fu_full[f];
    end
    disp_acc = nRST && disp_en && !sel_full && !(br_miss && disp_spec);
    disp_tag = '0;
    alloc_oh = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (disp_acc && (disp_fu == FU_W'(f)) && free_oh[f][s]) begin
          alloc_oh[f][s] = 1'b1;
          disp_tag       = TAG_W'(slot_tag(f, s, DEPTH));
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_age
    fust_age_sel #(.DEPTH(DEPTH)) u_age_sel (
      .CLK        (CLK),
      .nRST       (nRST),
      .alloc_oh_i (alloc_oh[g]),
      .rdy_i      (rdy_mask[g]),
      .oldest_o   (offer_oh[g])
    );
  end

  always_comb begin
    iss_valid = '0;
    iss_op    = '0;
    iss_tag   = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      iss_valid[f] = |rdy_mask[f];
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (offer_oh[f][s]) begin
          iss_op[f*OP_W +: OP_W]    = op_q[f][s];
          iss_tag[f*TAG_W +: TAG_W] = TAG_W'(slot_tag(f, s, DEPTH));
        end
      end
    end
  end

  // Slot update: wakeup/issue/complete, then flush, then a new dispatch wins.
  always_comb begin
    st_d        = st_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    spec_d      = spec_q;
    op_d        = op_q;
    disp_t1_w   = wake(disp_t1, done, done_tag);
    disp_t2_w   = wake(disp_t2, done, done_tag);
    disp_drop_d = disp_en && !disp_acc;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        t1_d[f][s] = wake(t1_q[f][s], done, done_tag);
        t2_d[f][s] = wake(t2_q[f][s], done, done_tag);
        case (st_q[f][s])
          FUST_WAIT: if ((t1_d[f][s] == '0) && (t2_d[f][s] == '0)) st_d[f][s] = FUST_RDY;
          FUST_RDY:  if (iss_ready[f] && offer_oh[f][s]) st_d[f][s] = FUST_EX;
          FUST_EX:   if (done_match(TAG_W'(slot_tag(f, s, DEPTH)), done, done_tag))
                       st_d[f][s] = FUST_EMPTY;
          default:   ;
        endcase
        if (alloc_oh[f][s]) begin
          st_d[f][s]   = ((disp_t1_w != '0) || (disp_t2_w != '0)) ? FUST_WAIT : FUST_RDY;
          t1_d[f][s]   = disp_t1_w;
          t2_d[f][s]   = disp_t2_w;
          spec_d[f][s] = disp_spec;
          op_d[f][s]   = disp_op;
        end else if (br_miss && spec_q[f][s]) begin
          st_d[f][s]   = FUST_EMPTY;
          spec_d[f][s] = 1'b0;
        end else if (br_resolved && !br_miss) begin
          spec_d[f][s] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          st_q[f][s]   <= FUST_EMPTY;
          t1_q[f][s]   <= '0;
          t2_q[f][s]   <= '0;
          spec_q[f][s] <= 1'b0;
          op_q[f][s]   <= '0;
        end
      end
      disp_drop_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      spec_q      <= spec_d;
      op_q        <= op_d;
      disp_drop_q <= disp_drop_d;
    end
  end

  assign disp_drop = disp_drop_q;

endmodule

// File: tb/tb_fust_s_multi.sv
// Directed bench for fust_s_multi: a dispatch-sequence model is checked every
// negedge, plus hand-computed literal expectations at key points.
module tb_fust_s_multi;

  localparam int NF = 3;
  localparam int DP = 2;
  localparam int OW = 80;
  localparam int TW = 3;
  localparam int EMPTY = 0, WAIT = 1, RDY = 2, EX = 3;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           disp_en;
  logic [1:0]     disp_fu;
  logic [OW-1:0]  disp_op;
  logic [TW-1:0]  disp_t1, disp_t2;
  logic           disp_spec;
  logic [TW-1:0]  disp_tag;
  logic [NF-1:0]  fu_full;
  logic           disp_drop;
  logic [NF-1:0]  done;
  logic [NF*TW-1:0] done_tag;
  logic [NF-1:0]  iss_valid, iss_ready;
  logic [NF*OW-1:0] iss_op;
  logic [NF*TW-1:0] iss_tag;
  logic           br_resolved, br_miss;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fust_s_multi dut (
    .CLK(CLK), .nRST(nRST),
    .disp_en(disp_en), .disp_fu(disp_fu), .disp_op(disp_op),
    .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_spec(disp_spec),
    .disp_tag(disp_tag), .fu_full(fu_full), .disp_drop(disp_drop),
    .done(done), .done_tag(done_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_tag(iss_tag),
    .br_resolved(br_resolved), .br_miss(br_miss)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: slots ordered by a global dispatch sequence number.
  int           m_st   [NF][DP];
  int           m_t1   [NF][DP];
  int           m_t2   [NF][DP];
  bit           m_spec [NF][DP];
  logic [OW-1:0] m_op  [NF][DP];
  int           m_seq  [NF][DP];
  int           seq_cnt;
  bit           m_drop;

  function automatic int tagof(int f, int s);
    return f * DP + s + 1;
  endfunction

  function automatic bit done_hit(int t);
    for (int k = 0; k < NF; k++)
      if (done[k] && int'(done_tag[k*TW +: TW]) == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit full_of(int f);
    for (int s = 0; s < DP; s++) if (m_st[f][s] == EMPTY) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int oldest_rdy(int f);
    int best;
    best = -1;
    for (int s = 0; s < DP; s++)
      if (m_st[f][s] == RDY && (best < 0 || m_seq[f][s] < m_seq[f][best])) best = s;
    return best;
  endfunction

  function automatic int free_slot(int f);
    for (int s = 0; s < DP; s++) if (m_st[f][s] == EMPTY) return s;
    return -1;
  endfunction

  function automatic bit disp_ok();
    if (!(nRST && disp_en && int'(disp_fu) < NF)) return 1'b0;
    return !full_of(int'(disp_fu)) && !(br_miss && disp_spec);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NF; f++)
      for (int s = 0; s < DP; s++) begin
        m_st[f][s] = EMPTY; m_t1[f][s] = 0; m_t2[f][s] = 0;
        m_spec[f][s] = 1'b0; m_op[f][s] = '0; m_seq[f][s] = 0;
      end
    seq_cnt = 0;
    m_drop  = 1'b0;
  endtask

  task automatic model_step();
    int off [NF];
    bit acc;
    int fs, df, t1b, t2b;
    acc = disp_ok();
    df  = int'(disp_fu);
    fs  = acc ? free_slot(df) : -1;
    for (int f = 0; f < NF; f++) off[f] = oldest_rdy(f);
    for (int f = 0; f < NF; f++)
      for (int s = 0; s < DP; s++) begin
        if (done_hit(m_t1[f][s])) m_t1[f][s] = 0;
        if (done_hit(m_t2[f][s])) m_t2[f][s] = 0;
        case (m_st[f][s])
          WAIT: if (m_t1[f][s] == 0 && m_t2[f][s] == 0) m_st[f][s] = RDY;
          RDY:  if (iss_ready[f] && off[f] == s) m_st[f][s] = EX;
          EX:   if (done_hit(tagof(f, s))) m_st[f][s] = EMPTY;
          default: ;
        endcase
        if (br_miss && m_spec[f][s]) begin
          m_st[f][s] = EMPTY; m_spec[f][s] = 1'b0;
        end else if (br_resolved) begin
          m_spec[f][s] = 1'b0;
        end
      end
    if (acc) begin
      t1b = done_hit(int'(disp_t1)) ? 0 : int'(disp_t1);
      t2b = done_hit(int'(disp_t2)) ? 0 : int'(disp_t2);
      m_st[df][fs]   = (t1b != 0 || t2b != 0) ? WAIT : RDY;
      m_t1[df][fs]   = t1b;
      m_t2[df][fs]   = t2b;
      m_spec[df][fs] = disp_spec;
      m_op[df][fs]   = disp_op;
      m_seq[df][fs]  = seq_cnt;
      seq_cnt++;
    end
    m_drop = disp_en && !acc;
  endtask

  // Compare DUT against model mid-cycle, then advance model across the next edge.
  always @(negedge CLK) begin : cmp
    logic [NF-1:0] ev, ef;
    logic [TW-1:0] et;
    int b;
    if (!nRST) model_reset();
    ev = '0;
    ef = '0;
    for (int f = 0; f < NF; f++) begin
      ef[f] = full_of(f);
      b = oldest_rdy(f);
      if (b >= 0) begin
        ev[f] = 1'b1;
        chk("iss_tag", 256'(iss_tag[f*TW +: TW]), 256'(tagof(f, b)));
        chk("iss_op", 256'(iss_op[f*OW +: OW]), 256'(m_op[f][b]));
      end
    end
    chk("iss_valid", 256'(iss_valid), 256'(ev));
    chk("fu_full", 256'(fu_full), 256'(ef));
    chk("disp_drop", 256'(disp_drop), 256'(m_drop));
    et = disp_ok() ? TW'(tagof(int'(disp_fu), free_slot(int'(disp_fu)))) : '0;
    chk("disp_tag", 256'(disp_tag), 256'(et));
    if (nRST) model_step();
  end

  task automatic idle();
    disp_en = 1'b0; disp_fu = '0; disp_op = '0; disp_t1 = '0; disp_t2 = '0;
    disp_spec = 1'b0; done = '0; done_tag = '0; iss_ready = '0;
    br_resolved = 1'b0; br_miss = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic disp(input int f, input logic [OW-1:0] op, input int t1, input int t2, input bit sp);
    disp_en = 1'b1; disp_fu = 2'(f); disp_op = op;
    disp_t1 = TW'(t1); disp_t2 = TW'(t2); disp_spec = sp;
  endtask

  task automatic set_done(input int k, input int t);
    done[k] = 1'b1;
    done_tag[k*TW +: TW] = TW'(t);
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Simple ALU op: dispatch, issue, complete
    disp(0, 80'hA1, 0, 0, 0); #1 chk("t2_disp_tag", 256'(disp_tag), 256'(1)); cyc();
    chk("t2_valid", 256'(iss_valid), 256'(3'b001));
    chk("t2_tag", 256'(iss_tag[2:0]), 256'(1));
    chk("t2_op", 256'(iss_op[79:0]), 256'(80'hA1));
    iss_ready = 3'b001; cyc();
    chk("t2_ex_valid", 256'(iss_valid), 256'(0));
    set_done(0, 1); cyc();

    // Same-cycle bypass of rs1 tag
    disp(1, 80'hB1, 1, 0, 0); set_done(0, 1); #1 chk("t3_disp_tag", 256'(disp_tag), 256'(3)); cyc();
    chk("t3_valid", 256'(iss_valid), 256'(3'b010));
    chk("t3_tag", 256'(iss_tag[5:3]), 256'(3));
    iss_ready = 3'b010; cyc();
    set_done(1, 3); cyc();

    // Fill FU0, reject a third dispatch, then wake the waiting older slot
    disp(0, 80'hC0, 5, 0, 0); #1 chk("t4_tag1", 256'(disp_tag), 256'(1)); cyc();
    disp(0, 80'hC1, 0, 0, 0); #1 chk("t4_tag2", 256'(disp_tag), 256'(2)); cyc();
    chk("t4_full", 256'(fu_full), 256'(3'b001));
    disp(0, 80'hC2, 0, 0, 0); #1 chk("t4_rej_tag", 256'(disp_tag), 256'(0)); cyc();
    chk("t4_drop", 256'(disp_drop), 256'(1));
    chk("t4_offer", 256'(iss_tag[2:0]), 256'(2));
    set_done(2, 5); cyc();
    chk("t4_drop_clr", 256'(disp_drop), 256'(0));
    chk("t4_older_rdy", 256'(iss_tag[2:0]), 256'(1));
    iss_ready = 3'b001; cyc();
    chk("t4_next", 256'(iss_tag[2:0]), 256'(2));
    iss_ready = 3'b001; set_done(0, 1); cyc();
    set_done(0, 2); cyc();
    chk("t4_empty", 256'(iss_valid), 256'(0));

    // Slot 1 dispatched before slot 0 is offered first
    disp(0, 80'hD0, 6, 0, 1); #1 chk("t5_tag1", 256'(disp_tag), 256'(1)); cyc();
    disp(0, 80'hD1, 0, 0, 0); #1 chk("t5_tag2", 256'(disp_tag), 256'(2)); cyc();
    br_miss = 1'b1; cyc();
    disp(0, 80'hD2, 0, 0, 0); #1 chk("t5_reuse", 256'(disp_tag), 256'(1)); cyc();
    chk("t5_first", 256'(iss_tag[2:0]), 256'(2));
    chk("t5_first_op", 256'(iss_op[79:0]), 256'(80'hD1));
    iss_ready = 3'b001; cyc();
    chk("t5_second", 256'(iss_tag[2:0]), 256'(1));
    iss_ready = 3'b001; cyc();
    set_done(0, 2); cyc();
    set_done(0, 1); cyc();

    // Mispredict flush with resolve asserted together
    disp(1, 80'hE0, 0, 0, 1); #1 chk("t6_tag3", 256'(disp_tag), 256'(3)); cyc();
    disp(2, 80'hE1, 3, 0, 1); iss_ready = 3'b010; #1 chk("t6_tag5", 256'(disp_tag), 256'(5)); cyc();
    disp(0, 80'hE2, 0, 0, 0); #1 chk("t6_tag1", 256'(disp_tag), 256'(1)); cyc();
    disp(1, 80'hE3, 0, 0, 1); #1 chk("t6_tag4", 256'(disp_tag), 256'(4)); cyc();
    chk("t6_pre_valid", 256'(iss_valid), 256'(3'b011));
    chk("t6_pre_tag4", 256'(iss_tag[5:3]), 256'(4));
    br_miss = 1'b1; br_resolved = 1'b1; iss_ready = 3'b010;
    disp(2, 80'hE4, 0, 0, 1); #1 chk("t6_spec_rej", 256'(disp_tag), 256'(0)); cyc();
    chk("t6_valid", 256'(iss_valid), 256'(3'b001));
    chk("t6_keep", 256'(iss_tag[2:0]), 256'(1));
    chk("t6_full", 256'(fu_full), 256'(0));
    chk("t6_drop", 256'(disp_drop), 256'(1));
    set_done(1, 3); cyc();
    chk("t6_late_done", 256'(iss_valid), 256'(3'b001));
    iss_ready = 3'b001; cyc();
    set_done(0, 1); cyc();
    disp(1, 80'hF0, 0, 0, 0); #1 chk("t6_reuse3", 256'(disp_tag), 256'(3)); cyc();

    // Async reset mid-run with four busy slots
    disp(1, 80'hF1, 0, 0, 0); cyc();
    disp(0, 80'hF2, 0, 0, 0); cyc();
    disp(0, 80'hF3, 0, 0, 0); cyc();
    chk("t1_busy_full", 256'(fu_full), 256'(3'b011));
    disp(2, 80'hF4, 0, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("t1_rst_valid", 256'(iss_valid), 256'(0));
    chk("t1_rst_full", 256'(fu_full), 256'(0));
    chk("t1_rst_tag", 256'(disp_tag), 256'(0));
    cyc();
    cyc();
    nRST = 1'b1;
    disp(0, 80'h11, 0, 0, 0); #1 chk("t1_post_tag", 256'(disp_tag), 256'(1)); cyc();
    chk("t1_post_valid", 256'(iss_valid), 256'(3'b001));
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
